ex_multicycle_unit: RTL and testbench
=====================================

// Module: ex_multicycle_unit
// PURPOSE
// Iterative multiply/divide unit for the EX stage; raises the stall_from_ex request that ctrl consumes.
// It obeys ctrl's stall_ex/flush_ex back. It executes HI/LO-class ops: MULT/MULTU/DIV/DIVU/MADD[U]/MSUB[U].
// The request is held until a 64-bit {hi,lo} result is ready. The result is presented for exactly the cycle(s) the instruction leaves EX.
// PARAMETERS
// MUL_LAT  3  multiply pipeline depth in cycles, >=1
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   asynchronous reset, active-high
// req_valid    in   1   EX slot holds a valid multicycle op
// op           in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU
// reg1         in   32  rs operand (dividend / multiplicand)
// reg2         in   32  rt operand (divisor / multiplier)
// hilo_in      in   64  forwarded {hi,lo}, used by MADD/MSUB only; sampled at accept
// pipe_stall   in   1   stall_ex from ctrl
// flush        in   1   flush_ex from ctrl
// stall_req    out  1   to ctrl stall_from_ex
// result_valid out  1   {hi,lo} result valid
// hilo_out     out  64  {hi,lo} result
// BEHAVIOUR
// - States: IDLE, MUL, DIV, FIX, DONE. Async rst -> IDLE, counter=0, all operand/result regs=0.
// - Reset output values: stall_req=0, result_valid=0, hilo_out=0.
// - stall_req = req_valid & (state!=DONE); combinational from regs + req_valid only.
//   * It never depends on pipe_stall or flush, so there is no loop through ctrl.
// - Accept (cycle 0): IDLE & req_valid & ~flush.
//   * Latch operand magnitudes, sign flags, op and hilo_in.
//   * MUL ops -> MUL with cnt=MUL_LAT-1; DIV ops -> DIV with cnt=31.
// - MUL: product pipeline of MUL_LAT stages; cnt decrements each cycle; cnt==0 -> DONE.
//   * DONE is reached at cycle MUL_LAT+1; stall_req is high MUL_LAT+1 cycles.
// - DIV: restoring radix-2, 1 quotient bit/cycle over |reg1|,|reg2| (unsigned for DIVU).
//   * 32 cycles, then FIX (apply signs), then DONE at cycle 34; stall_req is high 34 cycles.
// - Signed rules:
//   * quotient negative iff signs differ; remainder takes the dividend's sign.
//   * 0x80000000 / -1 -> lo=0x80000000, hi=0.
// - Divisor==0 (any div op): lo=0xFFFFFFFF, hi=reg1 as sampled. No exception; the same 34-cycle timing applies.
// - MULT/MULTU: hilo_out = 64-bit signed/unsigned product.
//   * MADD[U]: hilo_in + product. MSUB[U]: hilo_in - product. All mod 2^64.
// - DONE: result_valid=1, hilo_out stable, stall_req=0.
//   * Stay in DONE while pipe_stall=1 (MM back-pressure).
//   * pipe_stall=0 -> IDLE next cycle. result_valid=0 in every state except DONE.
// - flush=1 in any state -> IDLE next cycle; the result is discarded and the counter cleared.
//   * flush & accept-condition in the same cycle: no accept.
// - req_valid=0 while in MUL/DIV/FIX (no flush): abort to IDLE next cycle, same as flush.
// - Back-to-back: a new op arriving the cycle after leaving DONE sees IDLE and is accepted normally.
//   * No accept ever occurs from DONE.
// - rst mid-operation: immediate IDLE, outputs 0, no residue from the aborted op.
// TESTING
// - MULT reg1=-3 (0xFFFFFFFD), reg2=7
//   -> stall_req high 4 cycles; DONE at cycle 4; hilo_out=0xFFFFFFFF_FFFFFFEB.
// - DIVU reg1=100, reg2=7
//   -> stall_req high 34 cycles; DONE at cycle 34; hi=2, lo=14.
// - DIV 0xFFFFFFF9 / 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
// - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
// - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, 34-cycle timing.
// - MADD hilo_in=1, 2*3 -> 7.
// - MSUBU hilo_in=0, 1*1 -> 0xFFFFFFFF_FFFFFFFF.
// - DIV accepted, flush at cycle 10
//   -> IDLE at cycle 11, stall_req=0 when req_valid drops, result_valid never asserted.
//   * Next op runs with full latency.
// - MULT reaches DONE with pipe_stall=1 for 3 cycles
//   -> result_valid and hilo_out held 3+1 cycles, then IDLE.
//   * A second MULT immediately after gets a correct independent result.
// - Assert rst during DIV cycle 20 -> all outputs 0 asynchronously.
//   * After release, a fresh DIVU 9/3 gives lo=3, hi=0.

Source files
------------

// File: rtl/ex_multicycle_unit.sv
// Iterative multiply/divide unit for the EX stage: pipelined multiply, restoring
// radix-2 divide, {hi,lo} result held in DONE until the pipeline releases it.
module ex_multicycle_unit #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [63:0] hilo_in,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        stall_req,
  output logic        result_valid,
  output logic [63:0] hilo_out
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2((MUL_LAT > 32) ? MUL_LAT : 32);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_mode;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [31:0]   r_quo;
  logic [31:0]   r_rem;
  logic [31:0]   r_mag_b;
  logic [63:0]   r_acc;
  logic [63:0]   r_hilo;
  logic [63:0]   r_pipe [MUL_LAT];

  logic          w_accept;
  logic          w_is_div;
  logic          w_sa;
  logic          w_sb;
  logic [31:0]   w_mag_a;
  logic [31:0]   w_mag_b;
  logic [32:0]   w_trial;
  logic [63:0]   w_prod;
  logic [63:0]   w_mul_res;
  logic [31:0]   w_q;
  logic [31:0]   w_r;
  logic [63:0]   w_div_res;

  assign w_accept = (r_state == S_IDLE) & req_valid & ~flush;
  assign w_is_div = (op == 3'd2) || (op == 3'd3);
  assign w_sa     = ~op[0] & reg1[31];
  assign w_sb     = ~op[0] & reg2[31];
  assign w_mag_a  = w_sa ? -reg1 : reg1;
  assign w_mag_b  = w_sb ? -reg2 : reg2;

  // Partial remainder is always below the divisor, so 33 bits hold the trial.
  assign w_trial  = {r_rem, r_quo[31]} - {1'b0, r_mag_b};

  assign w_prod   = r_neg_q ? -r_pipe[MUL_LAT-1] : r_pipe[MUL_LAT-1];

  always_comb begin
    w_mul_res = w_prod;
    case (r_mode)
      2'b10:   w_mul_res = r_acc + w_prod;
      2'b11:   w_mul_res = r_acc - w_prod;
      default: w_mul_res = w_prod;
    endcase
  end

  // Divide-by-zero leaves the dividend magnitude as remainder, so hi needs no override.
  assign w_q       = r_neg_q ? -r_quo : r_quo;
  assign w_r       = r_neg_r ? -r_rem : r_rem;
  assign w_div_res = {w_r, (r_mag_b == '0) ? 32'hFFFF_FFFF : w_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    stall_req    = req_valid & (r_state != S_DONE);
    result_valid = (r_state == S_DONE);
    hilo_out     = (r_state == S_DONE) ? r_hilo : '0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) w_next = w_is_div ? S_DIV : S_MUL;
        S_MUL: begin
          if (!req_valid)         w_next = S_IDLE;
          else if (r_cnt == '0)   w_next = S_DONE;
        end
        S_DIV: begin
          if (!req_valid)         w_next = S_IDLE;
          else if (r_cnt == '0)   w_next = S_FIX;
        end
        S_FIX:  w_next = req_valid ? S_DONE : S_IDLE;
        S_DONE: if (!pipe_stall) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_mode  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_hilo  <= '0;
      for (int unsigned k = 0; k < unsigned'(MUL_LAT); k++) r_pipe[k] <= '0;
    end else begin
      if (w_next == S_IDLE)
        r_cnt <= '0;
      else if (w_accept)
        r_cnt <= w_is_div ? CW'(31) : CW'(MUL_LAT - 1);
      else if ((r_state == S_MUL || r_state == S_DIV) && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);

      if (w_accept) begin
        r_mode    <= op[2:1];
        r_neg_q   <= w_sa ^ w_sb;
        r_neg_r   <= w_sa;
        r_quo     <= w_mag_a;
        r_rem     <= '0;
        r_mag_b   <= w_mag_b;
        r_acc     <= hilo_in;
        r_pipe[0] <= {32'b0, w_mag_a} * {32'b0, w_mag_b};
      end else if (r_state == S_MUL) begin
        for (int unsigned k = 1; k < unsigned'(MUL_LAT); k++) r_pipe[k] <= r_pipe[k-1];
      end else if (r_state == S_DIV && w_next != S_IDLE) begin
        if (!w_trial[32]) begin
          r_rem <= w_trial[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end else begin
          r_rem <= {r_rem[30:0], r_quo[31]};
          r_quo <= {r_quo[30:0], 1'b0};
        end
      end

      if (w_next == S_DONE && r_state == S_MUL)      r_hilo <= w_mul_res;
      else if (w_next == S_DONE && r_state == S_FIX) r_hilo <= w_div_res;
    end
  end

endmodule

// File: tb/tb_ex_multicycle_unit.sv
// Directed self-checking bench for ex_multicycle_unit: latency, results,
// flush/abort, back-pressure hold and asynchronous reset.
module tb_ex_multicycle_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [63:0] hilo_in;
  logic        pipe_stall;
  logic        flush;
  logic        stall_req;
  logic        result_valid;
  logic [63:0] hilo_out;

  int n_assert = 0;
  int n_fail   = 0;

  ex_multicycle_unit #(.MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .op(op), .reg1(reg1), .reg2(reg2),
    .hilo_in(hilo_in), .pipe_stall(pipe_stall), .flush(flush),
    .stall_req(stall_req), .result_valid(result_valid), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op from IDLE, checks stall length, DONE cycle and result,
  // holds DONE for 'hold' extra cycles, then checks the exit to IDLE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hin, input int lat,
                        input logic [63:0] exp, input int hold);
    int n = 0;
    int n_stall = 0;
    op = o; reg1 = a; reg2 = b; hilo_in = hin; req_valid = 1'b1;
    #1;
    while (result_valid !== 1'b1 && n < 100) begin
      if (stall_req === 1'b1) n_stall++;
      tick();
      n++;
    end
    chk({tag, "_done_cycle"}, 64'(n), 64'(lat));
    chk({tag, "_stall_cycles"}, 64'(n_stall), 64'(lat));
    chk({tag, "_hilo"}, hilo_out, exp);
    chk({tag, "_stall_in_done"}, 64'(stall_req), 64'd0);
    pipe_stall = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_held_valid"}, 64'(result_valid), 64'd1);
      chk({tag, "_held_hilo"}, hilo_out, exp);
      if (i == hold - 1) pipe_stall = 1'b0;
    end
    tick();
    req_valid = 1'b0;
    #1;
    chk({tag, "_left_done"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; op = '0; reg1 = '0; reg2 = '0;
    hilo_in = '0; pipe_stall = 1'b0; flush = 1'b0;
    tick();
    chk("reset_stall", 64'(stall_req), 64'd0);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_hilo", hilo_out, 64'd0);
    rst = 1'b0;
    tick();

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 64'd0, 34, 64'h0000_0002_0000_000E, 0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 34, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 34, 64'h0000_0000_8000_0000, 0);
    run_op("divu_by0", 3'd3, 32'd5, 32'd0, 64'd0, 34, 64'h0000_0005_FFFF_FFFF, 0);
    run_op("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 64'd0, 34, 64'hFFFF_FFF9_FFFF_FFFF, 0);
    run_op("madd", 3'd4, 32'd2, 32'd3, 64'd1, 4, 64'd7, 0);
    run_op("msubu", 3'd7, 32'd1, 32'd1, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("msub_neg", 3'd6, 32'hFFFF_FFFE, 32'd3, 64'd10, 4, 64'd16, 0);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 4, 64'hFFFF_FFFE_0000_0001, 0);

    // Flush during DIV cycle 10, then a fresh op must take full latency.
    op = 3'd2; reg1 = 32'd100; reg2 = 32'd7; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall_indep", 64'(stall_req), 64'd1);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_stall_drop", 64'(stall_req), 64'd0);
    chk("flush_no_valid", 64'(result_valid), 64'd0);
    run_op("after_flush", 3'd3, 32'd100, 32'd7, 64'd0, 34, 64'h0000_0002_0000_000E, 0);

    // Flush coinciding with the accept condition must not accept.
    op = 3'd0; reg1 = 32'd3; reg2 = 32'd3; req_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    run_op("flush_at_accept", 3'd0, 32'd3, 32'd3, 64'd0, 4, 64'd9, 0);

    // Flush mid-MUL followed immediately by a new op.
    op = 3'd0; reg1 = 32'd3; reg2 = 32'd3; req_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_op("flush_mul_next", 3'd0, 32'd4, 32'd5, 64'd0, 4, 64'd20, 0);

    // Back-pressure hold, then back-to-back independent MULT.
    run_op("bp_mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    run_op("bp_next", 3'd0, 32'd5, 32'hFFFF_FFFC, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFEC, 0);

    // Asynchronous reset at DIV cycle 20.
    op = 3'd3; reg1 = 32'd1000; reg2 = 32'd3; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rst_div_stall", 64'(stall_req), 64'd0);
    chk("rst_div_valid", 64'(result_valid), 64'd0);
    chk("rst_div_hilo", hilo_out, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("rst_then_divu", 3'd3, 32'd9, 32'd3, 64'd0, 34, 64'h0000_0000_0000_0003, 0);

    // Asynchronous reset while holding a result in DONE.
    op = 3'd0; reg1 = 32'd6; reg2 = 32'd7; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pipe_stall = 1'b1;
    chk("rst_done_pre_valid", 64'(result_valid), 64'd1);
    chk("rst_done_pre_hilo", hilo_out, 64'd42);
    #2;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rst_done_valid", 64'(result_valid), 64'd0);
    chk("rst_done_hilo", hilo_out, 64'd0);
    tick();
    rst = 1'b0; pipe_stall = 1'b0;
    tick();
    chk("rst_done_idle", 64'(result_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
